// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write bypass, busy scoreboard and clear sweep
module regfile_mp #(
   parameter int XLEN    = 32,
   parameter int NREG    = 32,
   parameter int NRD     = 2,
   parameter int ZERO_X0 = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NRD*$clog2(NREG)-1:0] rd_addr,
   output logic [NRD*XLEN-1:0]      rd_data,
   output logic [NRD-1:0]           rd_busy,
   input  logic                     wr0_en,
   input  logic [$clog2(NREG)-1:0]  wr0_addr,
   input  logic [XLEN-1:0]          wr0_data,
   input  logic                     wr1_en,
   input  logic [$clog2(NREG)-1:0]  wr1_addr,
   input  logic [XLEN-1:0]          wr1_data,
   input  logic                     rsv_en,
   input  logic [$clog2(NREG)-1:0]  rsv_addr,
   input  logic                     clr_req,
   output logic                     clr_active
);

   localparam int AW = $clog2(NREG);

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   idx_q;
   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy_q;
   logic            sweeping;
   logic            we0, we1, rsv;

   // Address 0 is not a real storage location when it is hardwired to zero.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return !((ZERO_X0 != 0) && (a == '0));
   endfunction

   assign sweeping = (state_q == SWEEP);

   // The sweep owns the array: all external updates are dropped while it runs.
   assign we0 = wr0_en & ~sweeping & addr_ok(wr0_addr);
   assign we1 = wr1_en & ~sweeping & addr_ok(wr1_addr);
   assign rsv = rsv_en & ~sweeping & addr_ok(rsv_addr);

   // Sweep controller next-state and clr_active decode.
   always_comb begin
      state_d    = state_q;
      clr_active = 1'b0;
      case (state_q)
         IDLE: begin
            if (clr_req) state_d = SWEEP;
         end
         SWEEP: begin
            clr_active = 1'b1;
            if (idx_q == AW'(NREG - 1)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Sweep state and index; index wraps naturally since NREG is a power of two.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && clr_req) idx_q <= '0;
         else if (sweeping)              idx_q <= idx_q + AW'(1);
      end
   end

   // Array and scoreboard update; later assignments win, giving wr1 over wr0 and rsv over writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         busy_q <= '0;
      end else if (sweeping) begin
         regs[idx_q]   <= '0;
         busy_q[idx_q] <= 1'b0;
      end else begin
         if (we0) begin
            regs[wr0_addr]   <= wr0_data;
            busy_q[wr0_addr] <= 1'b0;
         end
         if (we1) begin
            regs[wr1_addr]   <= wr1_data;
            busy_q[wr1_addr] <= 1'b0;
         end
         if (rsv) busy_q[rsv_addr] <= 1'b1;
      end
   end

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [AW-1:0]   a;
      logic            hit0, hit1;
      logic [XLEN-1:0] data_g;
      logic            busy_g;

      assign a    = rd_addr[g*AW +: AW];
      assign hit0 = we0 && (wr0_addr == a);
      assign hit1 = we1 && (wr1_addr == a);

      // Read mux with same-cycle write forwarding; forced to zero during reset.
      always_comb begin
         data_g = regs[a];
         busy_g = busy_q[a] & ~hit0 & ~hit1;
         if (hit1)      data_g = wr1_data;
         else if (hit0) data_g = wr0_data;
         if (reset || !addr_ok(a)) begin
            data_g = '0;
            busy_g = 1'b0;
         end
      end

      assign rd_data[g*XLEN +: XLEN] = data_g;
      assign rd_busy[g]              = busy_g;
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp
module tb_regfile_mp;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int AW   = 5;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NRD*AW-1:0]    rd_addr;
   logic [NRD*XLEN-1:0]  rd_data;
   logic [NRD-1:0]       rd_busy;
   logic                 wr0_en, wr1_en, rsv_en, clr_req;
   logic [AW-1:0]        wr0_addr, wr1_addr, rsv_addr;
   logic [XLEN-1:0]      wr0_data, wr1_data;
   logic                 clr_active;

   regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_X0(1)) dut (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .clr_req(clr_req), .clr_active(clr_active)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: register contents, reservations, and remaining sweep work.
   logic [XLEN-1:0] m_regs [NREG];
   bit              m_busy [NREG];
   int              sweep_left;
   int              sweep_pos;

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      sweep_left = 0;
      sweep_pos  = 0;
   endtask

   function automatic logic [AW-1:0] port_addr(input int p);
      logic [NRD*AW-1:0] v;
      v = rd_addr;
      return v[p*AW +: AW];
   endfunction

   function automatic logic [XLEN-1:0] exp_data(input int p);
      logic [AW-1:0] a;
      a = port_addr(p);
      if (reset) return '0;
      if (sweep_left == 0 && a != 0) begin
         if (wr1_en && wr1_addr == a) return wr1_data;
         if (wr0_en && wr0_addr == a) return wr0_data;
      end
      return m_regs[a];
   endfunction

   function automatic logic exp_busy(input int p);
      logic [AW-1:0] a;
      a = port_addr(p);
      if (reset || a == 0) return 1'b0;
      if (sweep_left == 0 && ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a))) return 1'b0;
      return m_busy[a];
   endfunction

   task automatic model_edge();
      if (reset) begin
         model_reset();
      end else if (sweep_left > 0) begin
         m_regs[sweep_pos] = '0;
         m_busy[sweep_pos] = 1'b0;
         sweep_pos++;
         sweep_left--;
      end else begin
         if (wr0_en && wr0_addr != 0) begin m_regs[wr0_addr] = wr0_data; m_busy[wr0_addr] = 1'b0; end
         if (wr1_en && wr1_addr != 0) begin m_regs[wr1_addr] = wr1_data; m_busy[wr1_addr] = 1'b0; end
         if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
         if (clr_req) begin
            sweep_left = NREG;
            sweep_pos  = 0;
         end
      end
   endtask

   // One clock: compare all outputs mid-cycle, then advance the model at the edge.
   task automatic do_cycle(input string tag);
      @(negedge clk);
      for (int p = 0; p < NRD; p++) begin
         check($sformatf("%s.data%0d", tag, p), rd_data[p*XLEN +: XLEN], exp_data(p));
         check($sformatf("%s.busy%0d", tag, p), XLEN'(rd_busy[p]), XLEN'(exp_busy(p)));
      end
      check($sformatf("%s.clr_active", tag), XLEN'(clr_active), XLEN'(sweep_left > 0));
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      wr0_en = 0; wr0_addr = '0; wr0_data = '0;
      wr1_en = 0; wr1_addr = '0; wr1_data = '0;
      rsv_en = 0; rsv_addr = '0; clr_req = 0;
   endtask

   task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      rd_addr = {a1, a0};
   endtask

   initial begin
      int cnt;
      model_reset();
      idle_inputs();
      reset = 1'b1;
      set_rd(5, 7);
      wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEAD_BEEF;
      rsv_en = 1; rsv_addr = 7;
      #3;
      check("rst.data0", rd_data[31:0], '0);
      check("rst.busy1", XLEN'(rd_busy[1]), '0);
      do_cycle("rst");
      do_cycle("rst");
      reset = 1'b0;
      idle_inputs();

      // Write then read back.
      wr0_en = 1; wr0_addr = 5; wr0_data = 32'h1234;
      set_rd(0, 0);
      do_cycle("wr5");
      idle_inputs();
      set_rd(5, 0);
      #3;
      check("rd5.data", rd_data[31:0], 32'h1234);
      check("rd5.busy", XLEN'(rd_busy[0]), '0);
      do_cycle("rd5");

      // Dual write collision with forwarding.
      wr0_en = 1; wr0_addr = 7; wr0_data = 32'hAAAA;
      wr1_en = 1; wr1_addr = 7; wr1_data = 32'h5555;
      set_rd(0, 7);
      #3;
      check("coll.bypass", rd_data[63:32], 32'h5555);
      do_cycle("coll");
      idle_inputs();
      set_rd(7, 7);
      #3;
      check("coll.stored", rd_data[31:0], 32'h5555);
      do_cycle("coll_rd");

      // Register 0 ignores writes and reservations.
      wr0_en = 1; wr0_addr = 0; wr0_data = 32'hFFFF_FFFF;
      rsv_en = 1; rsv_addr = 0;
      set_rd(0, 0);
      #3;
      check("x0.data", rd_data[31:0], '0);
      do_cycle("x0");
      idle_inputs();
      #3;
      check("x0.after", rd_data[63:32], '0);
      check("x0.busy", XLEN'(rd_busy), '0);
      do_cycle("x0_rd");

      // Scoreboard: reserve, release by write, reservation beats write.
      rsv_en = 1; rsv_addr = 9;
      set_rd(9, 0);
      do_cycle("rsv9");
      idle_inputs();
      #3;
      check("rsv9.busy", XLEN'(rd_busy[0]), 1);
      wr1_en = 1; wr1_addr = 9; wr1_data = 32'h42;
      #1;
      check("wr9.busy", XLEN'(rd_busy[0]), 0);
      check("wr9.data", rd_data[31:0], 32'h42);
      do_cycle("wr9");
      idle_inputs();
      rsv_en = 1; rsv_addr = 9;
      wr0_en = 1; wr0_addr = 9; wr0_data = 32'h77;
      do_cycle("rsvwr9");
      idle_inputs();
      #3;
      check("rsvwr9.busy", XLEN'(rd_busy[0]), 1);
      check("rsvwr9.data", rd_data[31:0], 32'h77);
      do_cycle("rsvwr9_rd");

      // Random traffic against the model.
      for (int n = 0; n < 300; n++) begin
         wr0_en = 1'($urandom_range(0, 1)); wr0_addr = AW'($urandom); wr0_data = $urandom;
         wr1_en = 1'($urandom_range(0, 1)); wr1_addr = AW'($urandom); wr1_data = $urandom;
         rsv_en = 1'($urandom_range(0, 1)); rsv_addr = AW'($urandom);
         if ($urandom_range(0, 3) == 0) wr1_addr = wr0_addr;
         set_rd(($urandom_range(0, 2) == 0) ? wr0_addr : AW'($urandom),
                ($urandom_range(0, 2) == 0) ? wr1_addr : AW'($urandom));
         do_cycle("rand");
      end
      idle_inputs();

      // Fill, then sweep with a write attempt in the middle.
      for (int a = 1; a < NREG; a++) begin
         wr0_en = 1; wr0_addr = AW'(a); wr0_data = 32'(a) * 32'h1010 + 1;
         rsv_en = 1; rsv_addr = AW'(a);
         set_rd(AW'(a), AW'(a - 1));
         do_cycle("fill");
      end
      idle_inputs();
      clr_req = 1;
      do_cycle("clr_req");
      clr_req = 0;
      cnt = 0;
      while (clr_active === 1'b1 && cnt < 40) begin
         idle_inputs();
         if (cnt == 5) begin
            wr0_en = 1; wr0_addr = 3; wr0_data = 32'h99;
            rsv_en = 1; rsv_addr = 4;
            clr_req = 1;
         end
         set_rd(3, AW'($urandom));
         do_cycle("sweep");
         cnt++;
      end
      check("sweep.len", XLEN'(cnt), XLEN'(NREG));
      idle_inputs();
      for (int a = 0; a < NREG; a++) begin
         set_rd(AW'(a), AW'(NREG - 1 - a));
         #3;
         check("post.data0", rd_data[31:0], '0);
         check("post.busy", XLEN'(rd_busy), '0);
         do_cycle("post");
      end

      // Reset in the middle of a sweep.
      for (int a = 1; a < NREG; a++) begin
         wr1_en = 1; wr1_addr = AW'(a); wr1_data = $urandom | 32'h1;
         do_cycle("fill2");
      end
      idle_inputs();
      clr_req = 1;
      do_cycle("clr_req2");
      clr_req = 0;
      repeat (10) do_cycle("sweep2");
      set_rd(31, 20);
      reset = 1'b1;
      #2;
      check("rstmid.clr_active", XLEN'(clr_active), '0);
      check("rstmid.data0", rd_data[31:0], '0);
      check("rstmid.data1", rd_data[63:32], '0);
      model_reset();
      do_cycle("rstmid");
      reset = 1'b0;
      repeat (5) do_cycle("after_rst");
      check("after_rst.clr_active", XLEN'(clr_active), '0);
      wr0_en = 1; wr0_addr = 20; wr0_data = 32'hCAFE;
      do_cycle("after_wr");
      idle_inputs();
      #3;
      check("after_wr.data1", rd_data[63:32], 32'hCAFE);
      check("after_wr.data0", rd_data[31:0], '0);
      do_cycle("after_rd");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning register count, power of two >= 2.
REQ-003 SHALL have parameter NRD, default 2, meaning number of read ports.
REQ-004 SHALL have parameter ZERO_X0, default 1, meaning register 0 hardwired to zero when 1.
REQ-005 SHALL define localparam AW = $clog2(NREG).
REQ-006 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port rd_addr, input, NRD*AW, packed read addresses; port i uses bits [i*AW +: AW].
REQ-009 SHALL have port rd_data, output, NRD*XLEN, packed read data, combinational.
REQ-010 SHALL have port rd_busy, output, NRD, per-port pending-write flag, combinational.
REQ-011 SHALL have ports wr0_en/wr1_en, input, 1 each, write enables.
REQ-012 SHALL have ports wr0_addr/wr1_addr, input, AW each, write addresses.
REQ-013 SHALL have ports wr0_data/wr1_data, input, XLEN each, write data.
REQ-014 SHALL have port rsv_en, input, 1, reserve destination (mark busy).
REQ-015 SHALL have port rsv_addr, input, AW, register to reserve.
REQ-016 SHALL have port clr_req, input, 1, one-cycle pulse starting a sequential clear sweep.
REQ-017 SHALL have port clr_active, output, 1, high while the sweep runs.

Function
REQ-018 SHALL write wrN_data to reg[wrN_addr] at the rising edge when wrN_en=1.
REQ-019 SHALL give wr1 priority over wr0 when both are enabled to the same address.
REQ-020 SHALL bypass reads: if a write is enabled to rd_addr[i] this cycle, rd_data[i] SHALL equal that write data, wr1 over wr0; otherwise it SHALL equal the array contents.
REQ-021 SHALL, when ZERO_X0=1, ignore writes and reservations to address 0, read 0 from address 0 on every port, and hold rd_busy at 0 for address 0.
REQ-022 SHALL keep a NREG-bit busy vector: rsv_en sets busy[rsv_addr]; any enabled write clears busy[wrN_addr].
REQ-023 SHALL leave busy=1 when a reservation and a write hit the same address in the same cycle; the reservation wins.
REQ-024 SHALL drive rd_busy[i] = busy[rd_addr[i]] AND NOT (a write is enabled to rd_addr[i] this cycle).
REQ-025 SHALL implement an FSM with states IDLE and SWEEP; IDLE SHALL move to SWEEP on clr_req=1 and set the sweep index to 0.
REQ-026 SHALL, in SWEEP, clear reg[idx] and busy[idx] once per cycle, then increment idx; SWEEP SHALL return to IDLE after idx = NREG-1 is cleared, taking NREG cycles in total.
REQ-027 SHALL drive clr_active=1 exactly while in SWEEP.
REQ-028 SHALL, in SWEEP, ignore wr0/wr1/rsv and clr_req, disable bypass, and serve reads from array contents.
REQ-029 SHALL increment idx modulo NREG so it never exceeds NREG-1.

Reset
REQ-030 SHALL, on reset=1 and regardless of clk, clear all registers to 0, the busy vector to 0, and idx to 0, set state to IDLE, and set clr_active=0.
REQ-031 SHALL abort an in-progress SWEEP when reset is asserted; after reset deasserts, no sweep is active.
REQ-032 SHALL hold rd_data=0 and rd_busy=0 for all ports while reset is held.

Verification
REQ-033 Write and read: wr0 x5=0x1234 at edge, then rd_addr0=5 -> rd_data0=0x1234, rd_busy0=0.
REQ-034 Collision and bypass: wr0 x7=0xAAAA and wr1 x7=0x5555 in the same cycle, rd_addr1=7 -> rd_data1=0x5555 the same cycle, and x7=0x5555 after the edge.
REQ-035 x0 handling: wr0 x0=0xFFFF_FFFF and rsv x0 -> rd_data for address 0 stays 0 and rd_busy stays 0.
REQ-036 Scoreboard: rsv x9 -> rd_busy=1 for address 9; next cycle wr1 x9=0x42 -> rd_busy=0 that cycle with rd_data=0x42; rsv x9 plus wr0 x9 in the same cycle -> busy remains 1.
REQ-037 Sweep: fill x1..x31 with nonzero values, pulse clr_req -> clr_active=1 for exactly 32 cycles; a wr0 x3=0x99 during the sweep is dropped; all registers read 0 afterward.
REQ-038 Reset mid-sweep: assert reset at sweep cycle 10 -> clr_active=0 immediately and all reads 0; after release, clr_active stays 0 until the next clr_req.
